program_loader: RTL and testbench

//  Host-side writer for the fetch stage's instruction-memory load port. Receives a framed
//  16-bit word stream (valid/ready), drives write_enable_fm/write_data_fm/write_addr_fm,
//  and holds the fetch stage in reset (rst_fm) until a load completes with a good checksum.

---
 rtl/program_loader.sv | 128 ++++++++++++
 tb/tb_program_loader.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// Module   : program_loader
// Brief    : Framed host word stream -> instruction-memory load port writer;
//            holds the fetch stage in reset until a checksum-clean load.
// Revision : 1.0
// ============================================================================
module program_loader #(
   parameter logic [15:0] SYNC_WORD  = 16'h5AA5,
   parameter logic [32:0] ADDR_LIMIT = 33'd1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   input  logic [15:0] in_data,
   output logic        in_ready,
   output logic        write_enable_fm,
   output logic [15:0] write_data_fm,
   output logic [31:0] write_addr_fm,
   output logic        rst_fm,
   output logic        busy,
   output logic        done,
   output logic        error
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_ADDR_HI = 3'd1;
   localparam logic [2:0] S_ADDR_LO = 3'd2;
   localparam logic [2:0] S_COUNT   = 3'd3;
   localparam logic [2:0] S_DATA    = 3'd4;
   localparam logic [2:0] S_CKSUM   = 3'd5;
   localparam logic [2:0] S_DONE    = 3'd6;

   logic [2:0]  r_state;
   logic [31:0] r_addr;
   logic [15:0] r_count;
   logic [15:0] r_acc;
   logic        r_we;
   logic [15:0] r_wdata;
   logic [31:0] r_waddr;
   logic        r_rst_fm;
   logic        r_done;
   logic        r_error;

   logic        w_accept;
   logic        w_in_range;
   logic        w_frame_err;

   assign w_accept    = in_valid & in_ready;
   // 33-bit compare so ADDR_LIMIT can be raised to 2^32 (whole space writable)
   assign w_in_range  = ({1'b0, r_addr} < ADDR_LIMIT);
   assign w_frame_err = r_error | (in_data != r_acc);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= S_IDLE;
         r_addr   <= 32'd0;
         r_count  <= 16'd0;
         r_acc    <= 16'd0;
         r_we     <= 1'b0;
         r_wdata  <= 16'd0;
         r_waddr  <= 32'd0;
         r_rst_fm <= 1'b1;
         r_done   <= 1'b0;
         r_error  <= 1'b0;
      end else begin
         r_we <= 1'b0;
         if (w_accept) begin
            case (r_state)
               S_IDLE, S_DONE: begin
                  if (in_data == SYNC_WORD) begin
                     r_state  <= S_ADDR_HI;
                     r_rst_fm <= 1'b1;
                     r_done   <= 1'b0;
                     r_error  <= 1'b0;
                     r_acc    <= 16'd0;
                  end
               end
               S_ADDR_HI: begin
                  r_addr[31:16] <= in_data;
                  r_state       <= S_ADDR_LO;
               end
               S_ADDR_LO: begin
                  r_addr[15:0] <= in_data;
                  r_state      <= S_COUNT;
               end
               S_COUNT: begin
                  r_count <= in_data;
                  r_state <= (in_data == 16'd0) ? S_CKSUM : S_DATA;
               end
               S_DATA: begin
                  r_acc <= r_acc ^ in_data;
                  if (w_in_range) begin
                     r_we    <= 1'b1;
                     r_wdata <= in_data;
                     r_waddr <= r_addr;
                  end else begin
                     r_error <= 1'b1;
                  end
                  r_addr  <= r_addr + 32'd1;
                  r_count <= r_count - 16'd1;
                  if (r_count == 16'd1) begin
                     r_state <= S_CKSUM;
                  end
               end
               S_CKSUM: begin
                  r_state  <= S_DONE;
                  r_error  <= w_frame_err;
                  r_done   <= ~w_frame_err;
                  r_rst_fm <= w_frame_err;
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign in_ready        = 1'b1;
   assign write_enable_fm = r_we;
   assign write_data_fm   = r_wdata;
   assign write_addr_fm   = r_waddr;
   assign rst_fm          = r_rst_fm;
   assign done            = r_done;
   assign error           = r_error;
   assign busy            = (r_state != S_IDLE) && (r_state != S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_program_loader
// Brief    : Directed self-checking bench for program_loader.
// Revision : 1.0
// ============================================================================
module tb_program_loader;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic [15:0] in_data;

   logic        rdy1, we1, rstfm1, busy1, done1, err1;
   logic [15:0] wd1;
   logic [31:0] wa1;
   logic        rdy2, we2, rstfm2, busy2, done2, err2;
   logic [15:0] wd2;
   logic [31:0] wa2;

   int vecs  = 0;
   int fails = 0;
   int wr_cnt = 0;

   program_loader u_dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .in_ready(rdy1), .write_enable_fm(we1), .write_data_fm(wd1),
      .write_addr_fm(wa1), .rst_fm(rstfm1), .busy(busy1), .done(done1),
      .error(err1)
   );

   // Full 32-bit address space writable, used for the wrap case
   program_loader #(.ADDR_LIMIT(33'h1_0000_0000)) u_dut_wide (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .in_ready(rdy2), .write_enable_fm(we2), .write_data_fm(wd2),
      .write_addr_fm(wa2), .rst_fm(rstfm2), .busy(busy2), .done(done2),
      .error(err2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) if (we1 === 1'b1) wr_cnt++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [15:0] w);
      in_valid = 1'b1;
      in_data  = w;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic idle();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_write(input string tag, input logic [31:0] a, input logic [15:0] d);
      chk({tag, "_we"}, {31'd0, we1}, 32'd1);
      chk({tag, "_addr"}, wa1, a);
      chk({tag, "_data"}, {16'd0, wd1}, {16'd0, d});
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_ready"}, {31'd0, rdy1}, 32'd1);
      chk({tag, "_we"}, {31'd0, we1}, 32'd0);
      chk({tag, "_wdata"}, {16'd0, wd1}, 32'd0);
      chk({tag, "_waddr"}, wa1, 32'd0);
      chk({tag, "_rstfm"}, {31'd0, rstfm1}, 32'd1);
      chk({tag, "_busy"}, {31'd0, busy1}, 32'd0);
      chk({tag, "_done"}, {31'd0, done1}, 32'd0);
      chk({tag, "_error"}, {31'd0, err1}, 32'd0);
   endtask

   int base;

   initial begin
      reset    = 1'b0;
      in_valid = 1'b0;
      in_data  = 16'h0000;
      repeat (2) @(posedge clk);
      #1;
      chk_reset_vals("rst");
      @(negedge clk);
      reset = 1'b1;

      // Good frame, three back-to-back writes
      send(16'h5AA5);
      chk("t1_busy", {31'd0, busy1}, 32'd1);
      send(16'h0000); send(16'h0010); send(16'h0003);
      send(16'h1111); chk_write("t1_w0", 32'h10, 16'h1111);
      send(16'h2222); chk_write("t1_w1", 32'h11, 16'h2222);
      send(16'h4444); chk_write("t1_w2", 32'h12, 16'h4444);
      chk("t1_cks_busy", {31'd0, busy1}, 32'd1);
      send(16'h7777);
      chk("t1_we_off", {31'd0, we1}, 32'd0);
      chk("t1_done", {31'd0, done1}, 32'd1);
      chk("t1_rstfm", {31'd0, rstfm1}, 32'd0);
      chk("t1_error", {31'd0, err1}, 32'd0);
      chk("t1_busy_end", {31'd0, busy1}, 32'd0);
      chk("t1_hold_addr", wa1, 32'h12);

      // Bad checksum
      send(16'h5AA5);
      chk("t2_done_clr", {31'd0, done1}, 32'd0);
      chk("t2_rstfm_set", {31'd0, rstfm1}, 32'd1);
      send(16'h0000); send(16'h0010); send(16'h0003);
      send(16'h1111); chk_write("t2_w0", 32'h10, 16'h1111);
      send(16'h2222); chk_write("t2_w1", 32'h11, 16'h2222);
      send(16'h4444); chk_write("t2_w2", 32'h12, 16'h4444);
      send(16'h7776);
      chk("t2_error", {31'd0, err1}, 32'd1);
      chk("t2_done", {31'd0, done1}, 32'd0);
      chk("t2_rstfm", {31'd0, rstfm1}, 32'd1);

      // Address limit crossing
      base = wr_cnt;
      send(16'h5AA5);
      chk("t3_err_clr", {31'd0, err1}, 32'd0);
      send(16'h0000); send(16'h03FF); send(16'h0002);
      send(16'hAAAA); chk_write("t3_w0", 32'h3FF, 16'hAAAA);
      send(16'h5555);
      chk("t3_drop", {31'd0, we1}, 32'd0);
      chk("t3_err_sticky", {31'd0, err1}, 32'd1);
      send(16'hFFFF);
      idle();
      chk("t3_wrcnt", wr_cnt - base, 32'd1);
      chk("t3_error", {31'd0, err1}, 32'd1);
      chk("t3_done", {31'd0, done1}, 32'd0);
      chk("t3_rstfm", {31'd0, rstfm1}, 32'd1);

      // Garbage then zero-length frame, contiguous valid
      base = wr_cnt;
      send(16'h1234); send(16'hABCD);
      chk("t4_discard", {31'd0, busy1}, 32'd0);
      send(16'h5AA5); send(16'h0000); send(16'h0000); send(16'h0000);
      chk("t4_cks_busy", {31'd0, busy1}, 32'd1);
      send(16'h0000);
      idle();
      chk("t4_nowrite", wr_cnt - base, 32'd0);
      chk("t4_done", {31'd0, done1}, 32'd1);
      chk("t4_rstfm", {31'd0, rstfm1}, 32'd0);
      chk("t4_error", {31'd0, err1}, 32'd0);

      // Same with in_valid toggling
      send(16'h1234); idle();
      send(16'hABCD); idle();
      chk("t4t_discard_done", {31'd0, done1}, 32'd1);
      send(16'h5AA5); idle();
      chk("t4t_done_clr", {31'd0, done1}, 32'd0);
      send(16'h0000); idle();
      send(16'h0000); idle();
      send(16'h0000); idle();
      send(16'h0000); idle();
      chk("t4t_nowrite", wr_cnt - base, 32'd0);
      chk("t4t_done", {31'd0, done1}, 32'd1);
      chk("t4t_rstfm", {31'd0, rstfm1}, 32'd0);
      chk("t4t_error", {31'd0, err1}, 32'd0);

      // Asynchronous reset mid-DATA
      send(16'h5AA5); send(16'h0000); send(16'h0020); send(16'h0003);
      send(16'hAAAA); chk_write("t5_w0", 32'h20, 16'hAAAA);
      #2;
      reset = 1'b0;
      #1;
      chk_reset_vals("t5_rst");
      @(negedge clk);
      reset = 1'b1;
      send(16'h5AA5); send(16'h0000); send(16'h0040); send(16'h0001);
      send(16'hBEEF); chk_write("t5_w1", 32'h40, 16'hBEEF);
      send(16'hBEEF);
      chk("t5_done", {31'd0, done1}, 32'd1);
      chk("t5_rstfm", {31'd0, rstfm1}, 32'd0);

      // Address wrap on the full-space instance
      send(16'h5AA5); send(16'hFFFF); send(16'hFFFF); send(16'h0002);
      send(16'h1234);
      chk("t6_we0", {31'd0, we2}, 32'd1);
      chk("t6_addr0", wa2, 32'hFFFF_FFFF);
      chk("t6_data0", {16'd0, wd2}, 32'h1234);
      send(16'h5678);
      chk("t6_we1", {31'd0, we2}, 32'd1);
      chk("t6_addr1", wa2, 32'h0000_0000);
      chk("t6_data1", {16'd0, wd2}, 32'h5678);
      send(16'h444C);
      chk("t6_done", {31'd0, done2}, 32'd1);
      chk("t6_rstfm", {31'd0, rstfm2}, 32'd0);
      chk("t6_narrow_err", {31'd0, err1}, 32'd1);

      idle();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
      $finish;
   end

endmodule
`default_nettype wire
